// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared FSM encoding and default parameters for the step sequencer
package step_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
    localparam int DEF_PORTS  = 4;
    localparam int DEF_STEPS  = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_LOOP_W = 8;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: control/status bundle between a controller (master) and the sequencer (slave)
// Controls: start, abort, pause, loop_en, dwell[STEPS*CNT_W], pattern[STEPS*PORTS]
// Status:   port_out, step_idx, busy, done, aborted, loop_cnt
interface step_sequencer_if
    import step_seq_pkg::*;
#(
    parameter int PORTS  = DEF_PORTS,
    parameter int STEPS  = DEF_STEPS,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int LOOP_W = DEF_LOOP_W
);
    localparam int IDX_W = $clog2(STEPS);
    logic                   start;
    logic                   abort;
    logic                   pause;
    logic                   loop_en;
    logic [STEPS*CNT_W-1:0] dwell;
    logic [STEPS*PORTS-1:0] pattern;
    logic [PORTS-1:0]       port_out;
    logic [IDX_W-1:0]       step_idx;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic [LOOP_W-1:0]      loop_cnt;
    modport master (
        output start, abort, pause, loop_en, dwell, pattern,
        input  port_out, step_idx, busy, done, aborted, loop_cnt
    );
    modport slave (
        input  start, abort, pause, loop_en, dwell, pattern,
        output port_out, step_idx, busy, done, aborted, loop_cnt
    );
endinterface

// File: rtl/step_dwell_counter.sv
// step_dwell_counter: per-step dwell down-counter with load/decrement/hold and a zero flag
// Ports: clk, rst (async, active-high), load, dec (hold when neither), load_val[CNT_W], zero
module step_dwell_counter
    import step_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : dec ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: walks STEPS programmable steps, each driving a PORTS-wide pattern for dwell+1 cycles
// Ports: clk, rst (async, active-high), bus (step_sequencer_if.slave: start/abort/pause/loop_en,
//        dwell/pattern tables in; port_out/step_idx/busy/done/aborted/loop_cnt out, all registered)
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int PORTS  = DEF_PORTS,
    parameter int STEPS  = DEF_STEPS,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int LOOP_W = DEF_LOOP_W
) (
    input logic              clk,
    input logic              rst,
    step_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(STEPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, nxt, load_idx;
    logic [PORTS-1:0]  port_q, port_d;
    logic [LOOP_W-1:0] loop_q, loop_d;
    logic              done_q, done_d, aborted_q, aborted_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    step_dwell_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (bus.dwell[load_idx*CNT_W +: CNT_W]),
        .zero     (cnt_zero)
    );
    assign nxt = idx_q == LAST ? '0 : idx_q + 1'b1;
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        port_d    = port_q;
        loop_d    = loop_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        load_idx  = '0;
        if (state_q == IDLE) begin
            if (bus.start && !bus.abort) begin
                state_d  = RUN;
                idx_d    = '0;
                port_d   = bus.pattern[0 +: PORTS];
                loop_d   = '0;
                cnt_load = 1'b1;
            end
        end else if (bus.abort) begin
            state_d   = IDLE;
            idx_d     = '0;
            port_d    = '0;
            aborted_d = 1'b1;
        end else if (bus.pause) begin
            state_d = PAUSE;
        end else begin
            // leaving PAUSE behaves like RUN on the same cycle, so counting resumes immediately
            state_d = RUN;
            if (!cnt_zero) begin
                cnt_dec = 1'b1;
            end else if (idx_q != LAST || bus.loop_en) begin
                idx_d    = nxt;
                port_d   = bus.pattern[nxt*PORTS +: PORTS];
                loop_d   = idx_q == LAST ? loop_q + 1'b1 : loop_q;
                cnt_load = 1'b1;
                load_idx = nxt;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                port_d  = '0;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            port_q    <= '0;
            loop_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            port_q    <= port_d;
            loop_q    <= loop_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end
    assign bus.port_out = port_q;
    assign bus.step_idx = idx_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = done_q;
    assign bus.aborted  = aborted_q;
    assign bus.loop_cnt = loop_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed self-checking bench for step_sequencer
module tb_step_sequencer;
    logic clk, rst;
    int vectors = 0;
    int miscompares = 0;
    step_sequencer_if #(.PORTS(4), .STEPS(4), .CNT_W(8), .LOOP_W(8)) bus ();
    step_sequencer #(.PORTS(4), .STEPS(4), .CNT_W(8), .LOOP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
    // cycle c is the interval right after edge c-1; start is sampled at edge 0
    function automatic logic [3:0] exp_port(int c);
        return c == 1 ? 4'b0001 : c <= 3 ? 4'b0010 : c <= 6 ? 4'b0100 : c <= 10 ? 4'b1000 : 4'b0000;
    endfunction
    function automatic logic [1:0] exp_idx(int c);
        return c == 1 ? 2'd0 : c <= 3 ? 2'd1 : c <= 6 ? 2'd2 : c <= 10 ? 2'd3 : 2'd0;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic go;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.port_out !== 4'd0) begin miscompares++; $display("FAIL reset port_out got %b want 0000", bus.port_out); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", bus.busy); end
        vectors++; if (bus.step_idx !== 2'd0) begin miscompares++; $display("FAIL reset step_idx got %0d want 0", bus.step_idx); end
        vectors++; if (bus.loop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset loop_cnt got %0d want 0", bus.loop_cnt); end
        vectors++; if (bus.done !== 1'b0 || bus.aborted !== 1'b0) begin miscompares++; $display("FAIL reset pulses got %b%b want 00", bus.done, bus.aborted); end
        rst = 1'b0;
        go();
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL reset pre-async busy got %b want 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset async busy got %b want 0", bus.busy); end
        vectors++; if (bus.port_out !== 4'd0) begin miscompares++; $display("FAIL reset async port_out got %b want 0000", bus.port_out); end
        rst = 1'b0;
    endtask
    task automatic test_single_pass;
        go();
        for (int c = 1; c <= 12; c++) begin
            vectors++; if (bus.port_out !== exp_port(c)) begin miscompares++; $display("FAIL single port_out c%0d got %b want %b", c, bus.port_out, exp_port(c)); end
            vectors++; if (bus.step_idx !== exp_idx(c)) begin miscompares++; $display("FAIL single step_idx c%0d got %0d want %0d", c, bus.step_idx, exp_idx(c)); end
            vectors++; if (bus.busy !== (c <= 10)) begin miscompares++; $display("FAIL single busy c%0d got %b want %b", c, bus.busy, c <= 10); end
            vectors++; if (bus.done !== (c == 11)) begin miscompares++; $display("FAIL single done c%0d got %b want %b", c, bus.done, c == 11); end
            // rewrite step 1's table entries while it is active; they must not take effect
            if (c == 2) begin
                bus.pattern[7:4] = 4'b1111;
                bus.dwell[15:8]  = 8'd5;
            end
            if (c == 3) begin
                bus.pattern[7:4] = 4'b0010;
                bus.dwell[15:8]  = 8'd1;
            end
            if (c < 12) tick();
        end
    endtask
    task automatic test_loop;
        logic [3:0] ep;
        bus.loop_en = 1'b1;
        go();
        for (int c = 1; c <= 21; c++) begin
            ep = c <= 10 ? exp_port(c) : exp_port(c - 10);
            vectors++; if (bus.port_out !== ep) begin miscompares++; $display("FAIL loop port_out c%0d got %b want %b", c, bus.port_out, ep); end
            vectors++; if (bus.loop_cnt !== (c <= 10 ? 8'd0 : 8'd1)) begin miscompares++; $display("FAIL loop loop_cnt c%0d got %0d want %0d", c, bus.loop_cnt, c > 10); end
            vectors++; if (bus.done !== (c == 21)) begin miscompares++; $display("FAIL loop done c%0d got %b want %b", c, bus.done, c == 21); end
            if (c == 12) bus.loop_en = 1'b0;
            if (c < 21) tick();
        end
        tick();
    endtask
    task automatic test_pause;
        logic [3:0] ep;
        go();
        for (int c = 1; c <= 14; c++) begin
            ep = c == 1 ? 4'b0001 : c <= 3 ? 4'b0010 : c <= 9 ? 4'b0100 : c <= 13 ? 4'b1000 : 4'b0000;
            vectors++; if (bus.port_out !== ep) begin miscompares++; $display("FAIL pause port_out c%0d got %b want %b", c, bus.port_out, ep); end
            vectors++; if (bus.busy !== (c <= 13)) begin miscompares++; $display("FAIL pause busy c%0d got %b want %b", c, bus.busy, c <= 13); end
            vectors++; if (bus.done !== (c == 14)) begin miscompares++; $display("FAIL pause done c%0d got %b want %b", c, bus.done, c == 14); end
            if (c == 5) bus.pause = 1'b1;
            if (c == 8) bus.pause = 1'b0;
            if (c < 14) tick();
        end
        tick();
    endtask
    task automatic test_abort;
        go();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.step_idx !== 2'd1 || bus.port_out !== 4'b0010) begin miscompares++; $display("FAIL abort ignored-start c3 got idx %0d port %b want idx 1 port 0010", bus.step_idx, bus.port_out); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        vectors++; if (bus.port_out !== 4'd0) begin miscompares++; $display("FAIL abort port_out c4 got %b want 0000", bus.port_out); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort busy c4 got %b want 0", bus.busy); end
        vectors++; if (bus.aborted !== 1'b1) begin miscompares++; $display("FAIL abort aborted c4 got %b want 1", bus.aborted); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort done c4 got %b want 0", bus.done); end
        vectors++; if (bus.step_idx !== 2'd0) begin miscompares++; $display("FAIL abort step_idx c4 got %0d want 0", bus.step_idx); end
        tick();
        vectors++; if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort c5 got aborted %b busy %b want 0 0", bus.aborted, bus.busy); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vectors++; if (bus.busy !== 1'b0 || bus.aborted !== 1'b0) begin miscompares++; $display("FAIL abort start+abort idle got busy %b aborted %b want 0 0", bus.busy, bus.aborted); end
    endtask
    task automatic test_back_to_back;
        go();
        repeat (10) tick();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL b2b done c11 got %b want 1", bus.done); end
        go();
        vectors++; if (bus.busy !== 1'b1 || bus.port_out !== 4'b0001) begin miscompares++; $display("FAIL b2b restart c12 got busy %b port %b want 1 0001", bus.busy, bus.port_out); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL b2b done c12 got %b want 0", bus.done); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask
    task automatic test_reset_mid_run;
        bus.loop_en = 1'b1;
        go();
        repeat (14) tick();
        vectors++; if (bus.loop_cnt !== 8'd1 || bus.step_idx !== 2'd2) begin miscompares++; $display("FAIL rstmid pre c15 got loop %0d idx %0d want 1 2", bus.loop_cnt, bus.step_idx); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.loop_cnt !== 8'd0 || bus.step_idx !== 2'd0 || bus.busy !== 1'b0 || bus.port_out !== 4'd0) begin miscompares++; $display("FAIL rstmid async got loop %0d idx %0d busy %b port %b want 0 0 0 0000", bus.loop_cnt, bus.step_idx, bus.busy, bus.port_out); end
        rst = 1'b0;
        bus.loop_en = 1'b0;
        go();
        vectors++; if (bus.port_out !== 4'b0001 || bus.step_idx !== 2'd0 || bus.loop_cnt !== 8'd0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid restart got port %b idx %0d loop %0d busy %b want 0001 0 0 1", bus.port_out, bus.step_idx, bus.loop_cnt, bus.busy); end
        repeat (10) tick();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL rstmid done c11 got %b want 1", bus.done); end
        tick();
    endtask
    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pause   = 1'b0;
        bus.loop_en = 1'b0;
        bus.dwell   = {8'd3, 8'd2, 8'd1, 8'd0};
        bus.pattern = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        test_reset();
        test_single_pass();
        test_loop();
        test_pause();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/step_sequencer.md
# step_sequencer

Parametrised multi-step output sequencer for the control plane. A single `start` walks the block through `STEPS` programmable steps. Each step drives a `PORTS`-wide output pattern for a programmable dwell time. The block supports pause, abort and continuous loop mode. It replaces fixed hard-coded step chains with one configurable engine that reports status (`busy`, `done`, current step, loop count) to the controlling logic.

## Interface
- `PORTS`, 4: width of the per-step output pattern.
- `STEPS`, 4: number of steps (≥2); `IDX_W = $clog2(STEPS)`.
- `CNT_W`, 8: dwell counter width.
- `LOOP_W`, 8: loop counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin sequence; accepted only in IDLE.
- `abort` in 1: terminate sequence; accepted in RUN or PAUSE.
- `pause` in 1: level; freezes the sequence while high.
- `loop_en` in 1: sampled at expiry of the last step.
- `dwell` in STEPS*CNT_W: step i dwell at bits [i*CNT_W +: CNT_W].
- `pattern` in STEPS*PORTS: step i output at bits [i*PORTS +: PORTS].
- `port_out` out PORTS: registered pattern of the current step; 0 when not running.
- `step_idx` out IDX_W: current step.
- `busy` out 1: high in RUN or PAUSE.
- `done` out 1: one-cycle pulse at normal completion.
- `aborted` out 1: one-cycle pulse on abort.
- `loop_cnt` out LOOP_W: completed wrap count; wraps modulo 2^LOOP_W.

## Operation
- States: IDLE, RUN, PAUSE.
- Reset values: state IDLE; `port_out`, `step_idx`, `busy`, `done`, `aborted` and `loop_cnt` all 0.
- IDLE with `start`=1 and `abort`=0:
  - go to RUN.
  - `step_idx`=0, counter = dwell[0], `port_out` = pattern[0].
  - clear `loop_cnt`.
- IDLE with `start`=1 and `abort`=1: stay IDLE; no pulse.
- RUN, counter ≠ 0: counter decrements by 1.
- RUN, counter == 0 (step expiry):
  - If `step_idx` < STEPS-1: advance to the next step. Load dwell[next] and drive pattern[next].
  - If `step_idx` == STEPS-1 and `loop_en`=1: wrap to step 0 and increment `loop_cnt`.
  - If `step_idx` == STEPS-1 and `loop_en`=0: go to IDLE. Set `port_out`=0, `busy`=0 and pulse `done`.
- Step i lasts dwell[i]+1 cycles; dwell 0 gives a 1-cycle step.
- Dwell and pattern values are sampled at step entry only. Changing them mid-step has no effect until the next step entry. `port_out` holds its registered value.
- RUN with `pause`=1: go to PAUSE. The counter does not decrement that cycle. Expiry does not occur while `pause`=1.
- PAUSE:
  - Counter, `step_idx` and `port_out` are frozen; `busy` stays 1.
  - `pause`=0 returns to RUN, and decrementing resumes on that cycle.
- Priority: `abort` > `pause` > expiry/decrement.
- Abort (in RUN or PAUSE):
  - Next cycle: IDLE, `port_out`=0, `busy`=0, `step_idx`=0.
  - `aborted` pulses; no `done`.
- `start` while busy is ignored and is not queued.
- `rst` asserted at any time forces the reset values immediately (asynchronous). No pulse is issued.

## Timing
- `start` sampled at edge T: `busy`=1 and `port_out`=pattern[0] visible after edge T.
- A step boundary changes `port_out` and `step_idx` on the same edge.
- Total run length: sum over i of (dwell[i]+1) cycles, plus any pause cycles.
- `done` and `aborted` are high for exactly one cycle, in the first IDLE cycle. `busy` is already 0 in that cycle.
- A new `start` is accepted in the same cycle that `done` is high. Back-to-back runs therefore have one idle cycle between them.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `step_seq_pkg`:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
  - default parameter constants.
- One sub-module, `step_dwell_counter`:
  - load / decrement / hold controls.
  - `zero` flag output.
  - CNT_W wide.
- Top holds the FSM, step index, loop counter and output registers.

## Test plan
All scenarios use PORTS=4, STEPS=4, CNT_W=8; start is asserted at edge 0.
- **Reset:** assert `rst` asynchronously → all outputs 0 without waiting for a clock edge.
- **Single pass:** dwell={0,1,2,3}, patterns {0001,0010,0100,1000}, `loop_en`=0, start at edge 0 → `port_out` is:
  - 0001 in cycle 1,
  - 0010 in cycles 2-3,
  - 0100 in cycles 4-6,
  - 1000 in cycles 7-10;
  - then `done`=1 and `busy`=0 in cycle 11.
- **Loop:** same setup with `loop_en`=1 → 0001 reappears in cycle 11 with `loop_cnt`=1. Drop `loop_en` during the second pass → `done` in cycle 21 and `loop_cnt`=1.
- **Pause:** `pause` high for 3 cycles starting at cycle 5 → the 0100 step spans cycles 4-9, and `done` moves to cycle 14.
- **Abort and ignored start:** `start` in cycle 2 → ignored. `abort` in cycle 3 → cycle 4 shows `port_out`=0, `busy`=0, `aborted`=1 and `done`=0.
- **Reset mid-run:** `rst` asserted during step 2 → immediate return to reset values. The next `start` begins cleanly at step 0 with `loop_cnt`=0.
